// File: rtl/main_memory_pkg.sv
// Shared widths and types for the 256 x 4-bit main memory.
package main_memory_pkg;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 4;
  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/main_memory_bus_driver.sv
// W-bus tri-state driver for main memory; MAIN_MEMORY_RDREG_EN registers the
// read word and the drive enable (1-clock read latency).
module main_memory_bus_driver #(
  parameter int unsigned DATA_W = main_memory_pkg::DATA_W
) (
`ifdef MAIN_MEMORY_RDREG_EN
  input  logic              clk,
`endif
  input  logic              rst_n,
  input  logic              i_r_enable,
  input  logic              i_w_enable,
  input  logic [DATA_W-1:0] i_rd_word,
  output logic [DATA_W-1:0] o_wbus_data,
  output logic              o_bus_drive
);

`ifdef MAIN_MEMORY_RDREG_EN
  logic [DATA_W-1:0] r_rd_q;
  logic              r_drive_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_q    <= '0;
      r_drive_q <= 1'b0;
    end else begin
      r_rd_q    <= i_rd_word;
      r_drive_q <= i_r_enable & ~i_w_enable;
    end
  end

  assign o_bus_drive = r_drive_q;
  assign o_wbus_data = r_drive_q ? r_rd_q : 'z;
`else
  // Never drive during a write so the write source owns the bus.
  assign o_bus_drive = i_r_enable & ~i_w_enable & rst_n;
  assign o_wbus_data = o_bus_drive ? i_rd_word : 'z;
`endif

endmodule

// File: rtl/main_memory_ram.sv
// Main memory RAM: storage array and write-data mux; bus drive lives in
// main_memory_bus_driver. Optional MAIN_MEMORY_RDREG_EN gives a registered read.
module main_memory_ram #(
  parameter int unsigned ADDR_W = main_memory_pkg::ADDR_W,
  parameter int unsigned DATA_W = main_memory_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              w_enable,
  input  logic              r_enable,
  input  logic              manual_mode,
  input  logic [DATA_W-1:0] manual_data,
  input  logic [DATA_W-1:0] bus_wr_data,
  output logic [DATA_W-1:0] wbus_data,
  output logic              bus_drive
);
  import main_memory_pkg::*;

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_rd_word;

  assign w_wr_data = manual_mode ? manual_data : bus_wr_data;

  // Per-location compare: an unknown address matches nothing, so no write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_enable && (address == ADDR_W'(i))) begin
          r_mem[i] <= w_wr_data;
        end
      end
    end
  end

`ifdef MAIN_MEMORY_RDREG_EN
  // Write-first: a same-edge write to the read address returns the new word.
  assign w_rd_word = w_enable ? w_wr_data : r_mem[address];
`else
  assign w_rd_word = r_mem[address];
`endif

  main_memory_bus_driver #(
    .DATA_W (DATA_W)
  ) u_bus_driver (
`ifdef MAIN_MEMORY_RDREG_EN
    .clk         (clk),
`endif
    .rst_n       (rst_n),
    .i_r_enable  (r_enable),
    .i_w_enable  (w_enable),
    .i_rd_word   (w_rd_word),
    .o_wbus_data (wbus_data),
    .o_bus_drive (bus_drive)
  );

endmodule

// File: tb/tb_main_memory_ram.sv
// Directed self-checking bench for main_memory_ram (default and
// MAIN_MEMORY_RDREG_EN builds).
module tb_main_memory_ram;
  import main_memory_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  addr_t address;
  logic  w_enable;
  logic  r_enable;
  logic  manual_mode;
  data_t manual_data;
  data_t bus_wr_data;
  data_t wbus_data;
  logic  bus_drive;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  main_memory_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .w_enable    (w_enable),
    .r_enable    (r_enable),
    .manual_mode (manual_mode),
    .manual_data (manual_data),
    .bus_wr_data (bus_wr_data),
    .wbus_data   (wbus_data),
    .bus_drive   (bus_drive)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Let combinational reads settle, or wait out the registered read latency.
  task automatic settle();
`ifdef MAIN_MEMORY_RDREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic mem_write(input addr_t a, input logic man, input data_t md, input data_t bd);
    @(negedge clk);
    address     = a;
    manual_mode = man;
    manual_data = md;
    bus_wr_data = bd;
    r_enable    = 1'b0;
    w_enable    = 1'b1;
    @(posedge clk);
    #1;
    w_enable    = 1'b0;
  endtask

  task automatic read_check(input string tag, input addr_t a, input data_t exp);
    address  = a;
    r_enable = 1'b1;
    w_enable = 1'b0;
    settle();
    check({tag, "_drv"}, {31'd0, bus_drive}, 32'd1);
    check(tag, {28'd0, wbus_data}, {28'd0, exp});
  endtask

  initial begin
    rst_n       = 1'b0;
    address     = '0;
    w_enable    = 1'b0;
    r_enable    = 1'b1;
    manual_mode = 1'b0;
    manual_data = '0;
    bus_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_drive_low", {31'd0, bus_drive}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    read_check("rst_rd_00", 8'h00, 4'h0);
    read_check("rst_rd_0c", 8'h0C, 4'h0);
    read_check("rst_rd_ff", 8'hFF, 4'h0);

    mem_write(8'h0C, 1'b1, 4'hA, 4'h7);
    read_check("man_rd_0c", 8'h0C, 4'hA);

    mem_write(8'h0A, 1'b1, 4'hE, 4'h1);
    read_check("man_rd_0a", 8'h0A, 4'hE);
    read_check("keep_0c", 8'h0C, 4'hA);
    read_check("keep_0b", 8'h0B, 4'h0);

    mem_write(8'hFF, 1'b0, 4'hF, 4'h5);
    read_check("run_rd_ff", 8'hFF, 4'h5);
    read_check("keep_00", 8'h00, 4'h0);

    @(negedge clk);
    r_enable = 1'b0;
    settle();
    check("ren0_drive", {31'd0, bus_drive}, 32'd0);

    @(negedge clk);
    address     = 8'h00;
    manual_mode = 1'b0;
    bus_wr_data = 4'h9;
    w_enable    = 1'b1;
    r_enable    = 1'b1;
    #1;
    check("wr_rd_drive_pre", {31'd0, bus_drive}, 32'd0);
    @(posedge clk);
    #1;
    check("wr_rd_drive_post", {31'd0, bus_drive}, 32'd0);
    @(negedge clk);
    w_enable = 1'b0;
    read_check("wr_rd_landed", 8'h00, 4'h9);

    manual_mode = 1'b1;
    read_check("man_no_gate", 8'hFF, 4'h5);

`ifndef MAIN_MEMORY_RDREG_EN
    @(negedge clk);
    read_check("addr_sw_0c", 8'h0C, 4'hA);
    read_check("addr_sw_0a", 8'h0A, 4'hE);
`else
    @(negedge clk);
    r_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    address  = 8'h0C;
    r_enable = 1'b1;
    #1;
    check("lat_not_yet", {31'd0, bus_drive}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_drive", {31'd0, bus_drive}, 32'd1);
    check("lat_data", {28'd0, wbus_data}, 32'hA);
    mem_write(8'h0C, 1'b1, 4'h3, 4'h0);
    read_check("rdreg_rd_0c", 8'h0C, 4'h3);
    mem_write(8'h0C, 1'b1, 4'hA, 4'h0);
`endif

    @(negedge clk);
    address  = 8'h0C;
    r_enable = 1'b1;
    settle();
    check("pre_rst_drive", {31'd0, bus_drive}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_drive", {31'd0, bus_drive}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("post_rst_0c", 8'h0C, 4'h0);

    mem_write(8'h0A, 1'b1, 4'h6, 4'h0);
    @(negedge clk);
    address     = 8'h0A;
    manual_mode = 1'b1;
    manual_data = 4'h3;
    w_enable    = 1'b1;
    r_enable    = 1'b0;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    w_enable = 1'b0;
    rst_n    = 1'b1;
    read_check("abort_wr_0a", 8'h0A, 4'h0);
    read_check("post_rst_ff", 8'hFF, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
